music_box_state_controller: RTL and testbench
=============================================

Name: music_box_state_controller

Overview:
- Top-level mode selector for the music box UI: synchronises and debounces raw push-buttons, drives the 5-bit currentState bus consumed by every MusicBoxState_* mode module, and returns to DoNothing (state 0) when the active mode raises its stateComplete.
- Sits directly upstream of the mode modules.
- Owns the stale-completion guard: a mode's stateComplete may stay high for up to one 1 kHz period after exit.

Parameters:
- NUM_BUTTONS, 4, buttons and modes; legal range 1..8; button k selects state k+1.
- DEBOUNCE_CYCLES, 500000, consecutive stable clock_50Mhz cycles required to accept a level change (10 ms); legal range >= 1.
- WATCHDOG_CYCLES, 500000000, cycles allowed in one mode before forced exit (10 s); used only with the optional feature.

Ports:
- clock_50Mhz  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- buttons  in  NUM_BUTTONS  raw asynchronous button levels, 1 = pressed.
- stateComplete  in  NUM_BUTTONS  bit k driven by the mode module for state k+1.
- currentState  out  5  0 = DoNothing, k+1 = mode k.
- watchdogFired  out  1  one-cycle pulse on forced exit; constant 0 when the feature is compiled out.
- debugString  out  32  status word, layout below.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates on posedge clock_50Mhz.
- Reset values: currentState = 0, watchdogFired = 0, debugString = 0. Synchronisers, debounce counters, debounced levels, seenLow mask, counters and FSM all clear to 0/IDLE.
- Sync: 2-flop synchroniser per button.
- Debounce, per button:
  - Counter increments while the sync output differs from the debounced level; clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- Press event k: debounced level rises AND seenLow[k] = 1.
  - seenLow[k] sets once the debounced level is 0 after reset. The debounced level resets to 0, so seenLow sets on the first clean cycle.
  - A button held through reset is masked until it has been debounced low, then high again.
- FSM:
  - IDLE (currentState = 0):
    - On any press event, go to WAIT_LOW with currentState = k+1, registered the next cycle.
    - Simultaneous presses: the lowest index wins; the others are discarded.
  - WAIT_LOW: ignore stateComplete[currentState-1] until it is sampled 0, then go to ARMED. Stale completion from a prior run therefore cannot cause an immediate exit.
  - ARMED: stateComplete[currentState-1] = 1 -> IDLE (currentState = 0 next cycle); the complete counter increments.
- Presses in WAIT_LOW/ARMED are ignored (the ignored counter increments). A press coinciding with completion is also ignored and counted.
- Latency: raw press to currentState change = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Only the bit for the active mode is examined; other stateComplete bits are don't-care.
- debugString layout:
  - [4:0] currentState
  - [6:5] FSM code: IDLE = 0, WAIT_LOW = 1, ARMED = 2
  - [7] 0
  - [15:8] ignored-press count, saturates at 255
  - [23:16] completed-mode count, wraps at 256
  - [31:24] debounced levels, zero-extended
- Reset mid-operation: state returns to 0 on the cycle after reset is sampled; counters clear.

Optional Feature:
- STATE_WATCHDOG_EN defined:
  - A 32-bit cycle counter clears on entry to WAIT_LOW and runs in WAIT_LOW/ARMED.
  - When it reaches WATCHDOG_CYCLES-1 without completion: FSM goes to IDLE, currentState = 0, watchdogFired pulses for 1 cycle, the completed-mode count is not incremented.
  - Completion on the same cycle as timeout: completion wins, no pulse.
- Undefined: no counter logic; watchdogFired tied 0; a mode may stay active indefinitely.

Test Plan:
- DEBOUNCE_CYCLES = 4: buttons[0] rises and holds -> currentState = 1 exactly 7 cycles later; debugString[6:5] = 1.
- In state 1, stateComplete[0] held 1 from entry for 20 cycles, then 0 for 3, then 1 -> no exit during the initial high; exit to 0 one cycle after the second rise; debugString[23:16] = 1.
- buttons[2] and buttons[1] rise on the same cycle -> currentState = 2; buttons[2] is not replayed later; ignored count unchanged.
- Chatter on buttons[0] (toggle every 2 cycles for 20 cycles, then 0) -> currentState stays 0, debounced bit stays 0.
- buttons[3] held across a reset pulse -> no transition while held; after a release and a re-press, currentState = 4.
- With STATE_WATCHDOG_EN and WATCHDOG_CYCLES = 100: enter state 2 with stateComplete = 0 -> after 100 cycles currentState = 0 and watchdogFired = 1 for exactly one cycle; completed count unchanged.

Source files
------------

// File: rtl/music_box_state_controller.sv
// Mode selector for the music box: debounces push-buttons, drives currentState and
// returns to DoNothing on stateComplete. Define STATE_WATCHDOG_EN to enable the mode watchdog.
module music_box_state_controller #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WATCHDOG_CYCLES = 500000000
) (
    input  logic                   clock_50Mhz,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic [NUM_BUTTONS-1:0] stateComplete,
    output logic [4:0]             currentState,
    output logic                   watchdogFired,
    output logic [31:0]            debugString
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LOW = 2'd1,
        ARMED    = 2'd2
    } fsmState_t;

    logic [NUM_BUTTONS-1:0] sync1_q;
    logic [NUM_BUTTONS-1:0] sync2_q;
    logic [NUM_BUTTONS-1:0] deb_q;
    logic [NUM_BUTTONS-1:0] deb_d;
    logic [NUM_BUTTONS-1:0] debPrev_q;
    logic [NUM_BUTTONS-1:0] seenLow_q;
    logic [NUM_BUTTONS-1:0] seenLow_d;
    logic [DW-1:0]          debCnt_q [NUM_BUTTONS];
    logic [DW-1:0]          debCnt_d [NUM_BUTTONS];
    logic [1:0]             startup_q;
    logic                   startupDone;

    logic [NUM_BUTTONS-1:0] pressEvent;
    logic                   anyPress;
    logic [2:0]             pressIdx;
    logic                   activeDone;

    fsmState_t              state_q;
    logic [2:0]             activeIdx_q;
    logic [4:0]             currentState_q;
    logic [7:0]             ignoredCnt_q;
    logic [7:0]             completeCnt_q;
    logic [7:0]             debPad;

`ifdef STATE_WATCHDOG_EN
    localparam logic [31:0] WD_LAST = 32'(WATCHDOG_CYCLES - 1);
    logic [31:0]            wdCnt_q;
    logic                   watchdogFired_q;
`else
    logic                   unusedWatchdogParam;
    assign unusedWatchdogParam = ^32'(WATCHDOG_CYCLES);
`endif

    // The synchroniser output needs two post-reset edges before it reflects the pins.
    assign startupDone = (startup_q == 2'd2);

    always_comb begin
        deb_d = deb_q;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            debCnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (debCnt_q[k] == DEB_LAST) begin
                    deb_d[k] = ~deb_q[k];
                end else begin
                    debCnt_d[k] = debCnt_q[k] + 1'b1;
                end
            end
        end
    end

    // A button only arms once it has been seen cleanly released, so one held through reset stays masked.
    assign seenLow_d  = seenLow_q | ({NUM_BUTTONS{startupDone}} & ~deb_q & ~sync2_q);
    assign pressEvent = deb_q & ~debPrev_q & seenLow_q;

    always_comb begin
        anyPress = 1'b0;
        pressIdx = '0;
        for (int k = NUM_BUTTONS - 1; k >= 0; k--) begin
            if (pressEvent[k]) begin
                anyPress = 1'b1;
                pressIdx = 3'(k);
            end
        end
    end

    always_comb begin
        activeDone = 1'b0;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            if (activeIdx_q == 3'(k)) begin
                activeDone = stateComplete[k];
            end
        end
    end

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            debPrev_q <= '0;
            seenLow_q <= '0;
            startup_q <= '0;
            for (int k = 0; k < NUM_BUTTONS; k++) begin
                debCnt_q[k] <= '0;
            end
        end else begin
            sync1_q   <= buttons;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            debPrev_q <= deb_q;
            seenLow_q <= seenLow_d;
            if (!startupDone) begin
                startup_q <= startup_q + 2'd1;
            end
            for (int k = 0; k < NUM_BUTTONS; k++) begin
                debCnt_q[k] <= debCnt_d[k];
            end
        end
    end

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state_q         <= IDLE;
            activeIdx_q     <= '0;
            currentState_q  <= '0;
            ignoredCnt_q    <= '0;
            completeCnt_q   <= '0;
`ifdef STATE_WATCHDOG_EN
            wdCnt_q         <= '0;
            watchdogFired_q <= 1'b0;
`endif
        end else begin
`ifdef STATE_WATCHDOG_EN
            watchdogFired_q <= 1'b0;
            if (state_q != IDLE) begin
                wdCnt_q <= wdCnt_q + 32'd1;
            end
`endif
            if ((state_q != IDLE) && anyPress && (ignoredCnt_q != 8'hFF)) begin
                ignoredCnt_q <= ignoredCnt_q + 8'd1;
            end
            unique case (state_q)
                IDLE: begin
                    if (anyPress) begin
                        state_q        <= WAIT_LOW;
                        activeIdx_q    <= pressIdx;
                        currentState_q <= 5'(pressIdx) + 5'd1;
`ifdef STATE_WATCHDOG_EN
                        wdCnt_q        <= '0;
`endif
                    end
                end
                WAIT_LOW: begin
                    if (!activeDone) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (activeDone) begin
                        state_q        <= IDLE;
                        currentState_q <= '0;
                        completeCnt_q  <= completeCnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    currentState_q <= '0;
                end
            endcase
`ifdef STATE_WATCHDOG_EN
            // A completion on the timeout cycle takes priority over the forced exit.
            if ((state_q != IDLE) && (wdCnt_q == WD_LAST) && !((state_q == ARMED) && activeDone)) begin
                state_q         <= IDLE;
                currentState_q  <= '0;
                watchdogFired_q <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        debPad = '0;
        debPad[NUM_BUTTONS-1:0] = deb_q;
    end

    assign currentState = currentState_q;
    assign debugString  = {debPad, completeCnt_q, ignoredCnt_q, 1'b0, state_q, currentState_q};

`ifdef STATE_WATCHDOG_EN
    assign watchdogFired = watchdogFired_q;
`else
    assign watchdogFired = 1'b0;
`endif

endmodule

// File: tb/tb_music_box_state_controller.sv
// Scoreboard bench for music_box_state_controller with DEBOUNCE_CYCLES = 4.
// Expected transitions and timed status checks are queued by the stimulus and consumed by the monitor.
module tb_music_box_state_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  buttons;
    logic [3:0]  stateComplete;
    logic [4:0]  currentState;
    logic        watchdogFired;
    logic [31:0] debugString;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int t0;

    typedef struct {
        int         cyc;
        logic [4:0] state;
    } trans_t;

    typedef struct {
        int          cyc;
        logic [31:0] mask;
        logic [31:0] val;
        logic        wd;
        string       name;
    } chk_t;

    trans_t     transQ[$];
    chk_t       chkQ[$];
    logic [4:0] prevState = 5'd0;

    music_box_state_controller #(
        .NUM_BUTTONS     (4),
        .DEBOUNCE_CYCLES (4),
        .WATCHDOG_CYCLES (100)
    ) dut (
        .clock_50Mhz   (clk),
        .reset         (reset),
        .buttons       (buttons),
        .stateComplete (stateComplete),
        .currentState  (currentState),
        .watchdogFired (watchdogFired),
        .debugString   (debugString)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void pushTrans(input int c, input logic [4:0] s);
        trans_t e;
        e.cyc   = c;
        e.state = s;
        transQ.push_back(e);
    endfunction

    function automatic void pushChk(input int c, input logic [31:0] m, input logic [31:0] v,
                                    input logic w, input string n);
        chk_t e;
        e.cyc  = c;
        e.mask = m;
        e.val  = v;
        e.wd   = w;
        e.name = n;
        chkQ.push_back(e);
    endfunction

    task automatic applyStimulus(input logic [3:0] b, input logic [3:0] sc, input int hold);
        buttons       = b;
        stateComplete = sc;
        repeat (hold) @(negedge clk);
    endtask

    task automatic checkOutput(input chk_t c);
        logic bad;
        checks++;
        bad = ((debugString & c.mask) !== c.val) || (watchdogFired !== c.wd);
        if ((c.mask[4:0] == 5'h1F) && (currentState !== c.val[4:0])) bad = 1'b1;
        if (bad) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d debug=%h (masked %h) wd=%b state=%0d expected masked=%h wd=%b",
                     c.name, cyc, debugString, debugString & c.mask, watchdogFired, currentState,
                     c.val, c.wd);
        end
    endtask

    // Monitor: every change of currentState must match the next queued transition, at the queued cycle.
    always @(negedge clk) begin
        trans_t e;
        if (currentState !== prevState) begin
            checks++;
            if (transQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpectedTransition cyc=%0d got state=%0d from %0d expected no change",
                         cyc, currentState, prevState);
            end else begin
                e = transQ.pop_front();
                if ((e.cyc != cyc) || (e.state !== currentState)) begin
                    failures++;
                    $display("[TB] FAIL transition cyc=%0d state=%0d expected cyc=%0d state=%0d",
                             cyc, currentState, e.cyc, e.state);
                end
            end
            prevState = currentState;
        end
        for (int i = chkQ.size() - 1; i >= 0; i--) begin
            if (chkQ[i].cyc == cyc) begin
                checkOutput(chkQ[i]);
                chkQ.delete(i);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        buttons       = 4'b0000;
        stateComplete = 4'b0000;
        pushChk(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "resetState");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 5);

        // Single press: state 1 exactly 2 + 4 + 1 cycles after the raw edge.
        t0 = cyc;
        pushTrans(t0 + 7, 5'd1);
        pushChk(t0 + 7, 32'hFFFF_FFFF, 32'h0100_0021, 1'b0, "press0Entry");
        applyStimulus(4'b0001, 4'b0000, 7);

        // Stale completion held from entry must not exit; the second rise must.
        pushChk(cyc + 5, 32'h0000_007F, 32'h0000_0021, 1'b0, "staleHighWaitLow");
        applyStimulus(4'b0001, 4'b0001, 20);
        pushChk(cyc + 2, 32'h0000_007F, 32'h0000_0041, 1'b0, "armedAfterLow");
        applyStimulus(4'b0001, 4'b0000, 3);
        pushTrans(cyc + 1, 5'd0);
        pushChk(cyc + 2, 32'hFFFF_FFFF, 32'h0101_0000, 1'b0, "completeCount1");
        applyStimulus(4'b0000, 4'b0001, 2);
        applyStimulus(4'b0000, 4'b0000, 8);

        // Simultaneous presses on buttons 2 and 1: lowest index wins, the other is dropped.
        t0 = cyc;
        pushTrans(t0 + 7, 5'd2);
        pushChk(t0 + 7, 32'hFFFF_FFFF, 32'h0601_0022, 1'b0, "simulPress");
        applyStimulus(4'b0110, 4'b0000, 7);
        applyStimulus(4'b0110, 4'b0001, 3);
        pushTrans(cyc + 1, 5'd0);
        pushChk(cyc + 2, 32'hFFFF_FFFF, 32'h0602_0000, 1'b0, "simulExit");
        applyStimulus(4'b0110, 4'b0010, 1);
        applyStimulus(4'b0110, 4'b0000, 10);
        pushChk(cyc + 10, 32'hFFFF_FFFF, 32'h0002_0000, 1'b0, "noReplay");
        applyStimulus(4'b0000, 4'b0000, 10);

        // Press of another button while a mode is active is counted as ignored.
        t0 = cyc;
        pushTrans(t0 + 7, 5'd1);
        applyStimulus(4'b0001, 4'b0000, 7);
        pushChk(cyc + 8, 32'h0000_FF7F, 32'h0000_0141, 1'b0, "ignoredPress");
        applyStimulus(4'b0011, 4'b0000, 8);
        pushTrans(cyc + 1, 5'd0);
        pushChk(cyc + 11, 32'h00FF_FF00, 32'h0003_0100, 1'b0, "countsAfterIgnore");
        applyStimulus(4'b0000, 4'b0001, 1);
        applyStimulus(4'b0000, 4'b0000, 10);

        // Chatter shorter than the debounce window never changes the debounced level.
        t0 = cyc;
        pushChk(t0 + 5,  32'h0100_001F, 32'h0, 1'b0, "chatterA");
        pushChk(t0 + 13, 32'h0100_001F, 32'h0, 1'b0, "chatterB");
        pushChk(t0 + 22, 32'h0100_001F, 32'h0, 1'b0, "chatterC");
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0000, 2);
        end
        applyStimulus(4'b0000, 4'b0000, 6);

        // Button 3 held through reset stays masked until released and pressed again.
        applyStimulus(4'b1000, 4'b0000, 1);
        pushChk(cyc + 2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "resetClears");
        reset = 1'b1;
        applyStimulus(4'b1000, 4'b0000, 2);
        reset = 1'b0;
        pushChk(cyc + 20, 32'hFF00_001F, 32'h0800_0000, 1'b0, "heldMasked");
        applyStimulus(4'b1000, 4'b0000, 20);
        applyStimulus(4'b0000, 4'b0000, 10);
        t0 = cyc;
        pushTrans(t0 + 7, 5'd4);
        pushChk(t0 + 7, 32'hFFFF_FFFF, 32'h0800_0024, 1'b0, "rePress3");
        applyStimulus(4'b1000, 4'b0000, 7);
        applyStimulus(4'b1000, 4'b0000, 2);
        pushTrans(cyc + 1, 5'd0);
        pushChk(cyc + 2, 32'h00FF_0000, 32'h0001_0000, 1'b0, "exitMode4");
        applyStimulus(4'b0000, 4'b1000, 1);
        applyStimulus(4'b0000, 4'b0000, 10);

        // Long stay in state 2 with stateComplete low.
        t0 = cyc;
        pushTrans(t0 + 7, 5'd2);
        applyStimulus(4'b0010, 4'b0000, 7);
`ifdef STATE_WATCHDOG_EN
        pushTrans(cyc + 100, 5'd0);
        pushChk(cyc + 99,  32'h0000_001F, 32'h0000_0002, 1'b0, "wdBefore");
        pushChk(cyc + 100, 32'h00FF_001F, 32'h0001_0000, 1'b1, "wdFire");
        pushChk(cyc + 101, 32'h0000_001F, 32'h0000_0000, 1'b0, "wdPulseEnd");
        applyStimulus(4'b0000, 4'b0000, 105);
`else
        pushChk(cyc + 100, 32'h0000_001F, 32'h0000_0002, 1'b0, "noWdStay");
        pushChk(cyc + 105, 32'h0000_0060, 32'h0000_0040, 1'b0, "noWdArmed");
        applyStimulus(4'b0000, 4'b0000, 105);
        pushTrans(cyc + 1, 5'd0);
        pushChk(cyc + 2, 32'h00FF_0000, 32'h0002_0000, 1'b0, "noWdExit");
        applyStimulus(4'b0000, 4'b0010, 1);
`endif
        applyStimulus(4'b0000, 4'b0000, 5);

        foreach (chkQ[i]) begin
            checks++;
            failures++;
            $display("[TB] FAIL pendingCheck %s at cyc=%0d never evaluated, now cyc=%0d",
                     chkQ[i].name, chkQ[i].cyc, cyc);
        end
        foreach (transQ[i]) begin
            checks++;
            failures++;
            $display("[TB] FAIL missingTransition got none expected state=%0d at cyc=%0d",
                     transQ[i].state, transQ[i].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
